ioctl_rom_streamer: RTL and testbench

IOCTL_ROM_STREAMER -- requirements
Module: ioctl_rom_streamer

---
 rtl/ioctl_rom_streamer.sv | 153 +++++++++++++++
 tb/tb_ioctl_rom_streamer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_rom_streamer.sv
// Streams a byte range from a source memory onto a MiSTer-style ioctl download bus.
// Optional running byte checksum output: define IOCTL_STREAM_CHECKSUM_EN.
module ioctl_rom_streamer #(
  parameter int WR_GAP = 8,
  parameter int MEM_AW = 20
) (
  input  logic              i_clk,
  input  logic              RESETn,
  input  logic              start,
  input  logic [MEM_AW-1:0] src_base,
  input  logic [20:0]       length,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  input  logic              mem_ack,
  output logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_data,
  output logic              ioctl_wr,
`ifdef IOCTL_STREAM_CHECKSUM_EN
  output logic [15:0]       csum,
`endif
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    WRITE,
    GAP,
    DONE
  } state_t;

  // GAP is left once this many cycles have passed since WRITE; the remaining two
  // cycles of the strobe period are spent in REQ and WAIT.
  localparam logic [7:0] GAP_LAST = (WR_GAP > 3) ? 8'(WR_GAP - 3) : 8'd1;

  state_t            state_reg, state_next;
  logic [20:0]       cnt_reg, cnt_next;
  logic [20:0]       len_reg, len_next;
  logic [MEM_AW-1:0] base_reg, base_next;
  logic [24:0]       addr_reg, addr_next;
  logic [7:0]        data_reg, data_next;
  logic [7:0]        gap_reg, gap_next;
`ifdef IOCTL_STREAM_CHECKSUM_EN
  logic [15:0]       csum_reg, csum_next;
`endif

  always_ff @(posedge i_clk or negedge RESETn) begin
    if (!RESETn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      len_reg   <= '0;
      base_reg  <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      gap_reg   <= '0;
`ifdef IOCTL_STREAM_CHECKSUM_EN
      csum_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      len_reg   <= len_next;
      base_reg  <= base_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      gap_reg   <= gap_next;
`ifdef IOCTL_STREAM_CHECKSUM_EN
      csum_reg  <= csum_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    len_next   = len_reg;
    base_next  = base_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    gap_next   = gap_reg;
`ifdef IOCTL_STREAM_CHECKSUM_EN
    csum_next  = csum_reg;
`endif

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          base_next = src_base;
          len_next  = length;
          cnt_next  = '0;
`ifdef IOCTL_STREAM_CHECKSUM_EN
          csum_next = '0;
`endif
          state_next = (length != 21'd0) ? REQ : DONE;
        end
      end

      REQ: begin
        state_next = WAIT;
      end

      WAIT: begin
        if (mem_ack) begin
          data_next  = mem_data;
          addr_next  = {4'b0000, cnt_reg};
          state_next = WRITE;
        end
      end

      WRITE: begin
        cnt_next = cnt_reg + 21'd1;
        gap_next = 8'd1;
`ifdef IOCTL_STREAM_CHECKSUM_EN
        csum_next = csum_reg + {8'h00, data_reg};
`endif
        // For very short gaps the REQ/WAIT round trip alone covers the spacing.
        if (WR_GAP <= 3) begin
          state_next = (cnt_reg + 21'd1 < len_reg) ? REQ : DONE;
        end else begin
          state_next = GAP;
        end
      end

      GAP: begin
        if (gap_reg >= GAP_LAST) begin
          state_next = (cnt_reg < len_reg) ? REQ : DONE;
        end else begin
          gap_next = gap_reg + 8'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mem_addr   = base_reg + MEM_AW'(cnt_reg);
  assign mem_rd     = (state_reg == REQ) || (state_reg == WAIT);
  assign ioctl_wr   = (state_reg == WRITE);
  assign ioctl_addr = addr_reg;
  assign ioctl_data = data_reg;
  assign busy       = (state_reg == REQ) || (state_reg == WAIT) ||
                      (state_reg == WRITE) || (state_reg == GAP);
  assign done       = (state_reg == DONE);
`ifdef IOCTL_STREAM_CHECKSUM_EN
  assign csum       = csum_reg;
`endif

endmodule

// File: tb/tb_ioctl_rom_streamer.sv
// Scoreboard bench for ioctl_rom_streamer: a memory model answers reads, every
// ioctl_wr strobe is popped from an expectation queue and compared.
module tb_ioctl_rom_streamer;

  logic        i_clk;
  logic        RESETn;
  logic        start;
  logic [19:0] src_base;
  logic [20:0] length;
  logic [19:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        mem_ack;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic        busy;
  logic        done;
`ifdef IOCTL_STREAM_CHECKSUM_EN
  logic [15:0] csum;
`endif

  ioctl_rom_streamer #(.WR_GAP(8), .MEM_AW(20)) dut (
    .i_clk      (i_clk),
    .RESETn     (RESETn),
    .start      (start),
    .src_base   (src_base),
    .length     (length),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_ack    (mem_ack),
    .ioctl_addr (ioctl_addr),
    .ioctl_data (ioctl_data),
    .ioctl_wr   (ioctl_wr),
`ifdef IOCTL_STREAM_CHECKSUM_EN
    .csum       (csum),
`endif
    .busy       (busy),
    .done       (done)
  );

  int tests_run;
  int tests_failed;

  logic [7:0]  mem [0:1023];
  logic [32:0] exp_q [$];
  int          wr_cycles [$];
  int          rd_runs [$];
  logic [19:0] rd_addrs [$];
  int          cyc;
  int          wr_count;
  int          rd_total;
  int          mon_run;
  int          resp_run;
  int          ack_idx;
  int          slow_idx;
  int          slow_n;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Memory model: ack in the 2nd cycle of mem_rd (slow_n-th for byte slow_idx).
  initial begin
    mem_ack  = 1'b0;
    mem_data = 8'h00;
    resp_run = 0;
    forever begin
      @(negedge i_clk);
      mem_ack = 1'b0;
      if (mem_rd) begin
        resp_run++;
        if (resp_run == ((ack_idx == slow_idx) ? slow_n : 2)) begin
          mem_ack  = 1'b1;
          mem_data = mem[mem_addr[9:0]];
          ack_idx++;
        end
      end else begin
        resp_run = 0;
      end
    end
  end

  // Monitor and scoreboard.
  initial begin
    logic [32:0] e;
    cyc = 0; wr_count = 0; rd_total = 0; mon_run = 0;
    forever begin
      @(negedge i_clk);
      cyc++;
      if (ioctl_wr) begin
        wr_count++;
        wr_cycles.push_back(cyc);
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_strobe: got addr %0h data %0h, expected no strobe", ioctl_addr, ioctl_data);
        end else begin
          e = exp_q.pop_front();
          if ({ioctl_addr, ioctl_data} !== e) begin
            tests_failed++;
            $display("FAIL strobe: got addr %0h data %0h, expected addr %0h data %0h",
                     ioctl_addr, ioctl_data, e[32:8], e[7:0]);
          end
        end
      end
      if (mem_rd) begin
        if (mon_run == 0) rd_addrs.push_back(mem_addr);
        mon_run++;
        rd_total++;
      end else if (mon_run != 0) begin
        rd_runs.push_back(mon_run);
        mon_run = 0;
      end
    end
  end

  task automatic push_exp(input logic [19:0] base, input int n);
    logic [19:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + 20'(i);
      exp_q.push_back({25'(i), mem[a[9:0]]});
    end
  endtask

  task automatic clear_logs();
    exp_q.delete();
    wr_cycles.delete();
    rd_runs.delete();
    rd_addrs.delete();
    ack_idx  = 0;
    slow_idx = -1;
    slow_n   = 2;
  endtask

  task automatic pulse_start(input logic [19:0] base, input logic [20:0] len);
    @(negedge i_clk);
    src_base = base;
    length   = len;
    start    = 1'b1;
    @(negedge i_clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    start = 1'b0; src_base = '0; length = '0;
    repeat (3) @(negedge i_clk);
    tests_run++;
    if ({mem_rd, ioctl_wr, busy, done} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b, expected 0000", {mem_rd, ioctl_wr, busy, done});
    end
    tests_run++;
    if (ioctl_addr !== 25'd0 || ioctl_data !== 8'd0 || mem_addr !== 20'd0) begin
      tests_failed++;
      $display("FAIL reset_buses: got addr %0h data %0h mem_addr %0h, expected 0 0 0", ioctl_addr, ioctl_data, mem_addr);
    end
`ifdef IOCTL_STREAM_CHECKSUM_EN
    tests_run++;
    if (csum !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_csum: got %0h, expected 0", csum);
    end
`endif
    RESETn = 1'b1;
    repeat (3) @(negedge i_clk);
    tests_run++;
    if ({mem_rd, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got %b, expected 000", {mem_rd, busy, done});
    end
  endtask

  task automatic test_basic();
    bit ok;
    clear_logs();
    mem[10'h100] = 8'h11; mem[10'h101] = 8'h22; mem[10'h102] = 8'h33; mem[10'h103] = 8'h44;
    push_exp(20'h00100, 4);
    pulse_start(20'h00100, 21'd4);
    tests_run++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_busy: got busy %b done %b, expected 1 0", busy, done);
    end
    wait_done(200, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL basic_timeout: done got %b, expected 1", done);
    end
    tests_run++;
    if (busy !== 1'b0 || wr_cycles.size() != 4 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL basic_count: got busy %b strobes %0d left %0d, expected 0 4 0", busy, wr_cycles.size(), exp_q.size());
    end
    for (int i = 1; i < wr_cycles.size(); i++) begin
      tests_run++;
      if (wr_cycles[i] - wr_cycles[i-1] != 8) begin
        tests_failed++;
        $display("FAIL basic_spacing: got %0d cycles, expected 8", wr_cycles[i] - wr_cycles[i-1]);
      end
    end
  endtask

  task automatic test_zero_length();
    int wr0, rd0;
    clear_logs();
    test_reset();
    wr0 = wr_count; rd0 = rd_total;
    pulse_start(20'h00040, 21'd0);
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_len_done: got done %b busy %b, expected 1 0", done, busy);
    end
    repeat (6) @(negedge i_clk);
    tests_run++;
    if (wr_count != wr0 || rd_total != rd0) begin
      tests_failed++;
      $display("FAIL zero_len_activity: got %0d strobes %0d reads, expected 0 0", wr_count - wr0, rd_total - rd0);
    end
  endtask

  task automatic test_slow_ack();
    bit ok;
    clear_logs();
    slow_idx = 1;
    slow_n   = 20;
    push_exp(20'h00200, 3);
    pulse_start(20'h00200, 21'd3);
    wait_done(300, ok);
    tests_run++;
    if (!ok || exp_q.size() != 0 || rd_runs.size() != 3) begin
      tests_failed++;
      $display("FAIL slow_complete: got done %b left %0d reads %0d, expected 1 0 3", done, exp_q.size(), rd_runs.size());
    end
    for (int i = 0; i < rd_runs.size() && i < 3; i++) begin
      tests_run++;
      if (rd_runs[i] != ((i == 1) ? 20 : 2) || rd_addrs[i] !== 20'h00200 + 20'(i)) begin
        tests_failed++;
        $display("FAIL slow_read%0d: got %0d cycles at %0h, expected %0d cycles at %0h",
                 i, rd_runs[i], rd_addrs[i], (i == 1) ? 20 : 2, 20'h00200 + 20'(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen, n, wr0;
    bit ok;
    clear_logs();
    wr0 = wr_count;
    push_exp(20'h00300, 2);
    pulse_start(20'h00300, 21'd5);
    seen = 0; n = 0;
    while (seen < 2 && n < 200) begin
      @(negedge i_clk);
      if (ioctl_wr) seen++;
      n++;
    end
    repeat (2) @(negedge i_clk);
    #2 RESETn = 1'b0;
    #1;
    tests_run++;
    if ({mem_rd, ioctl_wr, busy, done} !== 4'b0000 || ioctl_addr !== 25'd0 ||
        ioctl_data !== 8'd0 || mem_addr !== 20'd0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got flags %b addr %0h data %0h mem_addr %0h, expected all 0",
               {mem_rd, ioctl_wr, busy, done}, ioctl_addr, ioctl_data, mem_addr);
    end
    repeat (3) @(negedge i_clk);
    RESETn = 1'b1;
    repeat (20) @(negedge i_clk);
    tests_run++;
    if (wr_count - wr0 != 2 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_abort: got %0d strobes busy %b, expected 2 0", wr_count - wr0, busy);
    end
    clear_logs();
    wr0 = wr_count;
    push_exp(20'h00340, 2);
    pulse_start(20'h00340, 21'd2);
    wait_done(200, ok);
    tests_run++;
    if (!ok || wr_count - wr0 != 2 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL midreset_restart: got done %b strobes %0d left %0d, expected 1 2 0", done, wr_count - wr0, exp_q.size());
    end
  endtask

  task automatic test_start_in_wait();
    int wr0;
    bit ok;
    clear_logs();
    slow_idx = 0;
    slow_n   = 6;
    wr0 = wr_count;
    push_exp(20'h00180, 3);
    pulse_start(20'h00180, 21'd3);
    @(negedge i_clk);
    tests_run++;
    if (mem_rd !== 1'b1 || ioctl_wr !== 1'b0) begin
      tests_failed++;
      $display("FAIL wait_state: got mem_rd %b ioctl_wr %b, expected 1 0", mem_rd, ioctl_wr);
    end
    src_base = 20'h00000;
    length   = 21'd7;
    start    = 1'b1;
    @(negedge i_clk);
    start    = 1'b0;
    wait_done(300, ok);
    tests_run++;
    if (!ok || wr_count - wr0 != 3 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL start_in_wait: got done %b strobes %0d left %0d, expected 1 3 0", done, wr_count - wr0, exp_q.size());
    end
  endtask

`ifdef IOCTL_STREAM_CHECKSUM_EN
  task automatic test_checksum();
    bit ok;
    clear_logs();
    mem[10'h3F0] = 8'hFF; mem[10'h3F1] = 8'hFF; mem[10'h3F2] = 8'h02;
    push_exp(20'h003F0, 3);
    pulse_start(20'h003F0, 21'd3);
    tests_run++;
    if (csum !== 16'h0000) begin
      tests_failed++;
      $display("FAIL csum_clear: got %0h, expected 0", csum);
    end
    wait_done(200, ok);
    tests_run++;
    if (!ok || csum !== 16'h0200) begin
      tests_failed++;
      $display("FAIL csum_value: got %0h done %b, expected 200 1", csum, done);
    end
  endtask
`endif

  initial begin
    tests_run = 0;
    tests_failed = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
    clear_logs();
    test_reset();
    test_basic();
    test_zero_length();
    test_slow_ack();
    test_reset_mid();
    test_start_in_wait();
`ifdef IOCTL_STREAM_CHECKSUM_EN
    test_checksum();
`endif
    repeat (5) @(negedge i_clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
